// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: default sizes,
// FSM state encoding and the word-address range check.
package lsu_pkg;

  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAG_W     = 6;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  // A word address is legal when every bit above the implemented range is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_bits);
    return (addr >> addr_bits) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Pipeline-side request/response handshake of the load/store unit.
// master = EX/MEM + MEM/WB side, slave = the load/store unit.
interface mem_stage_lsu_if
  import lsu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_rd;

  logic              resp_valid;
  logic              resp_we;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_rd;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_rd,
    input  req_ready, resp_valid, resp_we, resp_err, resp_data, resp_rd
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_rd,
    output req_ready, resp_valid, resp_we, resp_err, resp_data, resp_rd
  );

endinterface

// File: rtl/lsu_event_counter.sv
// Wrapping event counter with synchronous clear and increment enable.
module lsu_event_counter
  import lsu_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled events; clear wins over increment, overflow wraps to zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (clear)    count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one load/store, drives data_mem,
// captures its registered read data and returns a tagged one-cycle response.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_lsu_if.slave    lsu,
  output logic              busy,
  output logic              dm_r,
  output logic              dm_w,
  output logic [31:0]       dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  lsu_state_e        state, state_next;
  logic              accept;
  logic              in_range;
  logic              resp_valid;

  // Holding registers for the transaction in flight (addr/wdata live in dm_addr/dm_wdata).
  logic              hold_we;
  logic [TAG_W-1:0]  hold_rd;

  // Response registers: hold their value until the next RESP.
  logic              resp_we_q;
  logic              resp_err_q;
  logic [TAG_W-1:0]  resp_rd_q;
  logic [DATA_W-1:0] resp_data_q;

  assign lsu.req_ready  = (state == IDLE) && !rst;
  assign accept         = lsu.req_valid && lsu.req_ready;
  assign in_range       = addr_in_range(lsu.req_addr, ADDR_BITS);

  assign lsu.resp_valid = resp_valid;
  assign lsu.resp_we    = resp_we_q;
  assign lsu.resp_err   = resp_err_q;
  assign lsu.resp_rd    = resp_rd_q;
  assign lsu.resp_data  = resp_data_q;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_next = state;
    dm_r       = 1'b0;
    dm_w       = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_next = in_range ? ISSUE : RESP;
      ISSUE: begin
        if (hold_we) begin
          dm_w       = 1'b1;
          state_next = RESP;
        end else begin
          dm_r       = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the request at accept and build the response on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_we     <= 1'b0;
      hold_rd     <= '0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      resp_we_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_rd_q   <= '0;
      resp_data_q <= '0;
    end else if (accept) begin
      hold_we <= lsu.req_we;
      hold_rd <= lsu.req_rd;
      if (in_range) begin
        // dm_addr/dm_wdata only change for accesses that really reach data_mem.
        dm_addr <= lsu.req_addr;
        if (lsu.req_we) dm_wdata <= lsu.req_wdata;
      end else begin
        resp_we_q   <= lsu.req_we;
        resp_err_q  <= 1'b1;
        resp_rd_q   <= lsu.req_rd;
        resp_data_q <= '0;
      end
    end else if (state == ISSUE && hold_we) begin
      resp_we_q   <= 1'b1;
      resp_err_q  <= 1'b0;
      resp_rd_q   <= hold_rd;
      resp_data_q <= '0;
    end else if (state == CAPTURE) begin
      resp_we_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_rd_q   <= hold_rd;
      resp_data_q <= dm_rdata;
    end
  end

  lsu_event_counter #(.W(CNT_W)) u_load_count (
    .clk   (clk),
    .clear (rst),
    .inc   (resp_valid && !resp_err_q && !resp_we_q),
    .count (load_count)
  );

  lsu_event_counter #(.W(CNT_W)) u_store_count (
    .clk   (clk),
    .clear (rst),
    .inc   (resp_valid && !resp_err_q && resp_we_q),
    .count (store_count)
  );

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a data_mem model, a transaction-level
// reference model compared every cycle, and directed literal expectations.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int CNT_W  = 16;

  typedef logic [31:0] mem_t [256];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[2] = 32'd31;
    m[4] = 32'd9;
    m[5] = 32'hFFFF_F800;  // -2048
    m[6] = 32'd10;
    return m;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) tif ();

  logic              busy, dm_r, dm_w;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata = '0;
  logic [CNT_W-1:0]  load_count, store_count;

  mem_stage_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .lsu         (tif),
    .busy        (busy),
    .dm_r        (dm_r),
    .dm_w        (dm_w),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .load_count  (load_count),
    .store_count (store_count)
  );

  // data_mem: write-through store, registered read.
  mem_t d_mem = init_mem();
  always @(posedge clk) begin
    if (dm_w) d_mem[dm_addr[7:0]] <= dm_wdata;
    if (dm_r) dm_rdata <= d_mem[dm_addr[7:0]];
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- reference model ----------------
  // A transaction is described by its age (cycles since accept) and its
  // latency (error 1, store 2, load 3). The response appears when age == latency.
  mem_t ref_mem = init_mem();
  logic             m_live = 1'b0, m_pend = 1'b0;
  logic [1:0]       m_age = '0, m_lat = '0;
  logic             m_we = 1'b0, m_err = 1'b0;
  logic [TAG_W-1:0] m_rd = '0;
  logic [31:0]      m_data = '0, m_wdata = '0;
  logic             e_resp_we = 1'b0, e_resp_err = 1'b0;
  logic [TAG_W-1:0] e_resp_rd = '0;
  logic [31:0]      e_resp_data = '0, e_dm_addr = '0;
  logic [CNT_W-1:0] e_lc = '0, e_sc = '0;

  wire        mdl_ok   = ({32'd0, tif.req_addr} < 64'h1_0000);
  wire [1:0]  mdl_lat  = !mdl_ok ? 2'd1 : (tif.req_we ? 2'd2 : 2'd3);
  wire [31:0] mdl_data = (tif.req_we || !mdl_ok) ? 32'd0 : ref_mem[tif.req_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      m_live      <= 1'b1;
      m_pend      <= 1'b0;
      e_resp_we   <= 1'b0;
      e_resp_err  <= 1'b0;
      e_resp_rd   <= '0;
      e_resp_data <= '0;
      e_dm_addr   <= '0;
      e_lc        <= '0;
      e_sc        <= '0;
    end else if (m_pend) begin
      if (m_age == m_lat) begin
        m_pend <= 1'b0;
        if (!m_err) begin
          if (m_we) e_sc <= e_sc + 1'b1;
          else      e_lc <= e_lc + 1'b1;
        end
      end else begin
        m_age <= m_age + 2'd1;
        if (m_age + 2'd1 == m_lat) begin
          e_resp_we   <= m_we;
          e_resp_err  <= m_err;
          e_resp_rd   <= m_rd;
          e_resp_data <= m_data;
        end
      end
    end else if (tif.req_valid) begin
      m_pend  <= 1'b1;
      m_age   <= 2'd1;
      m_lat   <= mdl_lat;
      m_we    <= tif.req_we;
      m_err   <= !mdl_ok;
      m_rd    <= tif.req_rd;
      m_data  <= mdl_data;
      m_wdata <= tif.req_wdata;
      if (mdl_ok) e_dm_addr <= tif.req_addr;
      if (mdl_ok && tif.req_we) ref_mem[tif.req_addr[7:0]] <= tif.req_wdata;
      if (mdl_lat == 2'd1) begin
        e_resp_we   <= tif.req_we;
        e_resp_err  <= 1'b1;
        e_resp_rd   <= tif.req_rd;
        e_resp_data <= 32'd0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("req_ready",   tif.req_ready,  !m_pend && !rst);
      check("busy",        busy,           m_pend);
      check("resp_valid",  tif.resp_valid, m_pend && (m_age == m_lat));
      check("dm_r",        dm_r,           m_pend && !m_err && !m_we && (m_age == 2'd1));
      check("dm_w",        dm_w,           m_pend && !m_err &&  m_we && (m_age == 2'd1));
      check("dm_addr",     dm_addr,        e_dm_addr);
      check("resp_we",     tif.resp_we,    e_resp_we);
      check("resp_err",    tif.resp_err,   e_resp_err);
      check("resp_rd",     tif.resp_rd,    e_resp_rd);
      check("resp_data",   tif.resp_data,  e_resp_data);
      check("load_count",  load_count,     e_lc);
      check("store_count", store_count,    e_sc);
      if (m_pend && !m_err && m_we && m_age == 2'd1) check("dm_wdata", dm_wdata, m_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [TAG_W-1:0] rd);
    tif.req_valid = 1'b1;
    tif.req_we    = we;
    tif.req_addr  = addr;
    tif.req_wdata = wdata;
    tif.req_rd    = rd;
  endtask

  // Returns at the negedge preceding the accept edge, or reports a timeout.
  task automatic wait_ready(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tif.req_ready) ok = 1'b1;
    end
    if (!ok) check({name, "_accept_timeout"}, 1'b0, 1'b1);
  endtask

  // Counts negedges after the accept edge until resp_valid; 0 on timeout.
  task automatic wait_resp(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (tif.resp_valid) lat = i;
    end
    if (lat == 0) check({name, "_resp_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic xact(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [TAG_W-1:0] rd,
                      input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                      input logic [CNT_W-1:0] exp_lc, input logic [CNT_W-1:0] exp_sc);
    logic ok;
    int   lat;
    drive_req(we, addr, wdata, rd);
    wait_ready(name, ok);
    if (ok) begin
      @(posedge clk);
      #1 tif.req_valid = 1'b0;
      wait_resp(name, lat);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_data"},    tif.resp_data, exp_data);
      check({name, "_err"},     tif.resp_err, exp_err);
      check({name, "_rd"},      tif.resp_rd, rd);
      check({name, "_we"},      tif.resp_we, we);
      @(negedge clk);
      check({name, "_pulse"},   tif.resp_valid, 1'b0);
      check({name, "_lcount"},  load_count, exp_lc);
      check({name, "_scount"},  store_count, exp_sc);
    end
    tif.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ok;
    int   lat;
    tif.req_valid = 1'b0;
    tif.req_we    = 1'b0;
    tif.req_addr  = '0;
    tif.req_wdata = '0;
    tif.req_rd    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy",    busy, 1'b0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wd",   dm_wdata, 32'd0);
    check("rst_ready",   tif.req_ready, 1'b1);
    @(posedge clk);
    #1;

    xact("ld2",   1'b0, 32'd2,          32'd0,         6'd5,  32'd31,         1'b0, 3, 16'd1, 16'd0);
    xact("st3",   1'b1, 32'd3,          32'hDEADBEEF,  6'd7,  32'd0,          1'b0, 2, 16'd1, 16'd1);
    xact("ld3",   1'b0, 32'd3,          32'd0,         6'd8,  32'hDEADBEEF,   1'b0, 3, 16'd2, 16'd1);
    xact("ld5",   1'b0, 32'd5,          32'd0,         6'd9,  32'hFFFF_F800,  1'b0, 3, 16'd3, 16'd1);
    xact("oor",   1'b0, 32'h0001_0000,  32'd0,         6'd10, 32'd0,          1'b1, 1, 16'd3, 16'd1);

    // Back-to-back loads with req_valid held high.
    drive_req(1'b0, 32'd4, 32'd0, 6'd11);
    wait_ready("b2b_a", ok);
    @(posedge clk);
    #1 drive_req(1'b0, 32'd6, 32'd0, 6'd12);
    @(negedge clk);
    check("b2b_ready_low", tif.req_ready, 1'b0);
    check("b2b_busy",      busy, 1'b1);
    wait_resp("b2b_a", lat);
    check("b2b_a_lat",  lat + 1, 3);
    check("b2b_a_data", tif.resp_data, 32'd9);
    check("b2b_a_rd",   tif.resp_rd, 6'd11);
    @(negedge clk);
    check("b2b_ready_again", tif.req_ready, 1'b1);
    @(posedge clk);
    #1 tif.req_valid = 1'b0;
    wait_resp("b2b_b", lat);
    check("b2b_b_lat",  lat, 3);
    check("b2b_b_data", tif.resp_data, 32'd10);
    check("b2b_b_rd",   tif.resp_rd, 6'd12);
    @(negedge clk);
    check("b2b_lcount", load_count, 16'd5);
    @(posedge clk);
    #1;

    // Reset while a load sits in CAPTURE.
    drive_req(1'b0, 32'd2, 32'd0, 6'd13);
    wait_ready("rstmid", ok);
    @(posedge clk);
    #1 tif.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstmid_in_capture", busy, 1'b1);
    @(negedge clk);
    check("rstmid_busy",   busy, 1'b0);
    check("rstmid_resp",   tif.resp_valid, 1'b0);
    check("rstmid_lcount", load_count, 16'd0);
    check("rstmid_scount", store_count, 16'd0);
    check("rstmid_ready",  tif.req_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_resp", tif.resp_valid, 1'b0);
      check("rstmid_idle_ready", tif.req_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    xact("ld6", 1'b0, 32'd6, 32'd0, 6'd14, 32'd10, 1'b0, 3, 16'd1, 16'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
